// File: rtl/serial_convertfrommultisymbols.sv
// Sequential redundant multi-symbol to binary converter: resolves SYMBOLSPERCYCLE symbols per cycle, LSB chunk first.
// Optional signed-symbol mode is enabled with `define MULTISYMBOL_SIGNED_EN.
module serial_convertfrommultisymbols #(
  parameter int NUMSYMBOLS          = 32,
  parameter int SYMBOLSPERCYCLE     = 8,
  parameter int INPUTSYMBOLBITWIDTH = 35,
  parameter int LOGRADIX            = 33,
  localparam int OUTPUTBITWIDTH     = NUMSYMBOLS*LOGRADIX,
  localparam int NUMCHUNKS          = NUMSYMBOLS/SYMBOLSPERCYCLE,
  localparam int AUXBITWIDTH        = INPUTSYMBOLBITWIDTH-LOGRADIX+1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [INPUTSYMBOLBITWIDTH-1:0] data_in [NUMSYMBOLS],
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUTPUTBITWIDTH-1:0]      data_out,
  output logic [AUXBITWIDTH-1:0]         dataaux_out
);

  localparam int CHUNKW = SYMBOLSPERCYCLE*LOGRADIX;
  localparam int ACCW   = CHUNKW + AUXBITWIDTH;
  localparam int KW     = $clog2(NUMCHUNKS+1);

`ifdef MULTISYMBOL_SIGNED_EN
  typedef logic signed [ACCW-1:0] acc_t;

  function automatic acc_t ext_sym(input logic [INPUTSYMBOLBITWIDTH-1:0] s);
    return acc_t'($signed(s));
  endfunction

  function automatic acc_t ext_carry(input logic [AUXBITWIDTH-1:0] c);
    return acc_t'($signed(c));
  endfunction
`else
  typedef logic [ACCW-1:0] acc_t;

  function automatic acc_t ext_sym(input logic [INPUTSYMBOLBITWIDTH-1:0] s);
    return acc_t'(s);
  endfunction

  function automatic acc_t ext_carry(input logic [AUXBITWIDTH-1:0] c);
    return acc_t'(c);
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                         state;
  logic [KW-1:0]                  k;
  logic [AUXBITWIDTH-1:0]         carry;
  logic [INPUTSYMBOLBITWIDTH-1:0] sym [NUMSYMBOLS];
  logic [OUTPUTBITWIDTH-1:0]      data_r;
  logic [AUXBITWIDTH-1:0]         aux_r;
  logic                           in_ready_r;
  logic                           out_valid_r;

  acc_t                           chunk_sum;
  logic [AUXBITWIDTH-1:0]         carry_next;
  int                             base;

  // The chunk sum never exceeds AUXBITWIDTH bits above the chunk, so the carry is exact.
  always_comb begin
    base = 0;
    if (k < KW'(NUMCHUNKS))
      base = int'(k)*SYMBOLSPERCYCLE;
    chunk_sum = ext_carry(carry);
    for (int j = 0; j < SYMBOLSPERCYCLE; j++)
      chunk_sum = chunk_sum + (ext_sym(sym[base+j]) << (j*LOGRADIX));
    carry_next = AUXBITWIDTH'(chunk_sum >>> CHUNKW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      carry       <= '0;
      for (int i = 0; i < NUMSYMBOLS; i++)
        sym[i] <= '0;
      data_r      <= '0;
      aux_r       <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (in_valid && in_ready_r) begin
            sym        <= data_in;
            carry      <= '0;
            k          <= '0;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          // Extra step after the last chunk publishes the final carry.
          if (k == KW'(NUMCHUNKS)) begin
            aux_r       <= carry;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            data_r[int'(k)*CHUNKW +: CHUNKW] <= chunk_sum[CHUNKW-1:0];
            carry <= carry_next;
            k     <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign data_out    = data_r;
  assign dataaux_out = aux_r;

endmodule

// File: tb/tb_serial_convertfrommultisymbols.sv
// Directed bench for serial_convertfrommultisymbols with a full-width reference sum for the random cases.
module tb_serial_convertfrommultisymbols;
  localparam int NS  = 32;
  localparam int SPC = 8;
  localparam int ISW = 35;
  localparam int LR  = 33;
  localparam int OW  = NS*LR;
  localparam int AW  = ISW-LR+1;
  localparam int TW  = OW+AW;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [ISW-1:0] sym [NS];
  logic           out_valid;
  logic           out_ready;
  logic [OW-1:0]  data_out;
  logic [AW-1:0]  dataaux_out;

  int errors = 0;
  int checks = 0;
  logic [TW-1:0] e;

  always #5 clk = ~clk;

  serial_convertfrommultisymbols #(
    .NUMSYMBOLS(NS), .SYMBOLSPERCYCLE(SPC), .INPUTSYMBOLBITWIDTH(ISW), .LOGRADIX(LR)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(sym),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .dataaux_out(dataaux_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    int fd;
    fd = -1;
    checks++;
    assert (got === exp) else begin
      errors++;
      for (int i = OW-1; i >= 0; i--)
        if (got[i] !== exp[i]) fd = i;
      $error("FAIL %s: observed[127:0] %h expected[127:0] %h first differing bit %0d",
             tag, got[127:0], exp[127:0], fd);
    end
  endtask

  function automatic logic [OW-1:0] spaced(input int start);
    logic [OW-1:0] v;
    v = '0;
    for (int i = start; i < NS; i++) v[i*LR] = 1'b1;
    return v;
  endfunction

  function automatic logic [TW-1:0] model();
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < NS; i++) begin
`ifdef MULTISYMBOL_SIGNED_EN
      t = t + (TW'($signed(sym[i])) << (i*LR));
`else
      t = t + (TW'(sym[i]) << (i*LR));
`endif
    end
    return t;
  endfunction

  task automatic set_all(input logic [ISW-1:0] v);
    for (int i = 0; i < NS; i++) sym[i] = v;
  endtask

  task automatic txn(input string tag, input logic [OW-1:0] ed, input logic [AW-1:0] ea);
    int lat;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd5);
    chkw({tag, "_data"}, data_out, ed);
    chk({tag, "_aux"}, 64'(dataaux_out), 64'(ea));
    chk({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
  endtask

  task automatic handshake(input string tag);
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready_next"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_all('0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chkw("rst_data", data_out, '0);
    chk("rst_aux", 64'(dataaux_out), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    set_all(35'd1);
    txn("ones", spaced(0), '0);
    handshake("ones");

    set_all(35'h2_0000_0000);
    txn("pow33", spaced(1), 3'd1);
    handshake("pow33");

    set_all(35'h1_FFFF_FFFF);
    sym[0] = 35'h2_0000_0000;
    txn("ripple", '0, 3'd1);
    handshake("ripple");

    // Backpressure: result must hold while out_ready is low.
    set_all(35'd3);
    sym[5] = 35'h3_1234_5678;
    e = model();
    out_ready = 1'b0;
    txn("bp", e[OW-1:0], e[TW-1:OW]);
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NS; i++) sym[i] = ISW'({$urandom, $urandom});
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chkw("bp_data_hold", data_out, e[OW-1:0]);
      chk("bp_aux_hold", 64'(dataaux_out), 64'(e[TW-1:OW]));
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    handshake("bp");

    // Reset during the second RUN cycle.
    set_all(35'd5);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rr_out_valid", 64'(out_valid), 64'd0);
    chkw("rr_data", data_out, '0);
    chk("rr_aux", 64'(dataaux_out), 64'd0);
    chk("rr_in_ready_rst", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rr_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("rr_no_valid", 64'(out_valid), 64'd0);
    end
    set_all(35'd7);
    e = model();
    txn("after_rst", e[OW-1:0], e[TW-1:OW]);
    handshake("after_rst");

`ifdef MULTISYMBOL_SIGNED_EN
    set_all('0);
    sym[0] = 35'h7_FFFF_FFFF;
    txn("neg1", '1, '1);
    handshake("neg1");
`endif

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NS; i++) sym[i] = ISW'({$urandom, $urandom});
      e = model();
      txn("rand", e[OW-1:0], e[TW-1:OW]);
      handshake("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
